// File: rtl/stopwatch_axi_pkg.sv
// Shared constants and types for the stopwatch AXI4-Lite register block.
// Optional alarm/IRQ logic is built when STOPWATCH_ALARM_EN is defined.
package stopwatch_axi_pkg;

  localparam logic [31:0] DEFAULT_VERSION = 32'h0002_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] OFF_VERSION    = 8'h00;
  localparam logic [7:0] OFF_GLOBAL     = 8'h04;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h08;
  localparam logic [7:0] OFF_IRQ_ENABLE = 8'h0C;
  localparam logic [7:0] CH_BASE        = 8'h10;
  localparam logic [7:0] CH_STRIDE      = 8'h10;

  localparam int CTRL_APPLY = 0;
  localparam int CTRL_RUN   = 1;
  localparam int CTRL_CLEAR = 2;
  localparam int CTRL_LAP   = 3;

  typedef enum logic [1:0] {
    G_VERSION,
    G_CTRL,
    G_IRQ_STATUS,
    G_IRQ_ENABLE
  } glob_reg_e;

  typedef enum logic [1:0] {
    C_TEST_VALUE,
    C_CTRL,
    C_LAP,
    C_ALARM
  } ch_reg_e;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/stopwatch_axi_channel.sv
// One stopwatch channel: test value, run/pulses, lap capture, alarm.
// Alarm register and compare exist only with STOPWATCH_ALARM_EN.
module stopwatch_axi_channel
  import stopwatch_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  ch_reg_e     wr_reg,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        clr_all,
  input  logic [31:0] ch_time,
  output logic [31:0] test_value,
  output logic        apply,
  output logic        clear,
  output logic        run,
  output logic [31:0] lap,
  output logic [31:0] alarm,
  output logic        irq_set
);

  logic [31:0] test_value_q, test_value_d;
  logic [31:0] lap_q, lap_d;
  logic        apply_q, apply_d;
  logic        clear_q, clear_d;
  logic        run_q, run_d;
  logic        ctrl_wr;

  assign ctrl_wr = wr_en && (wr_reg == C_CTRL) && wstrb[0];

  always_comb begin
    test_value_d = test_value_q;
    lap_d        = lap_q;
    apply_d      = ctrl_wr && wdata[CTRL_APPLY];
    clear_d      = clr_all || (ctrl_wr && wdata[CTRL_CLEAR]);
    run_d        = clr_all ? 1'b0 : run_q;
    if (wr_en && (wr_reg == C_TEST_VALUE))
      test_value_d = strb_merge(test_value_q, wdata, wstrb);
    if (ctrl_wr) begin
      run_d = wdata[CTRL_RUN];
      if (wdata[CTRL_LAP]) lap_d = ch_time;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      test_value_q <= '0;
      lap_q        <= '0;
      apply_q      <= 1'b0;
      clear_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      test_value_q <= test_value_d;
      lap_q        <= lap_d;
      apply_q      <= apply_d;
      clear_q      <= clear_d;
      run_q        <= run_d;
    end
  end

  assign test_value = test_value_q;
  assign apply      = apply_q;
  assign clear      = clear_q;
  assign run        = run_q;
  assign lap        = lap_q;

`ifdef STOPWATCH_ALARM_EN
  logic [31:0] alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (wr_en && (wr_reg == C_ALARM))
      alarm_d = strb_merge(alarm_q, wdata, wstrb);
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= '0;
    else       alarm_q <= alarm_d;
  end

  // A zero alarm means disarmed
  assign alarm   = alarm_q;
  assign irq_set = run_q && (alarm_q != '0) && (ch_time == alarm_q);
`else
  assign alarm   = '0;
  assign irq_set = 1'b0;
`endif

endmodule

// File: rtl/stopwatch_ctrl_axi.sv
// AXI4-Lite control/status block for NUM_CH stopwatch channels.
// Define STOPWATCH_ALARM_EN to build alarm compare and the irq output.
module stopwatch_ctrl_axi
  import stopwatch_axi_pkg::*;
#(
  parameter int          AW      = 8,
  parameter int          NUM_CH  = 4,
  parameter logic [31:0] VERSION = DEFAULT_VERSION
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*NUM_CH-1:0]  ch_time,
  output logic [32*NUM_CH-1:0]  test_value,
  output logic [NUM_CH-1:0]     apply_test_value,
  output logic [NUM_CH-1:0]     ch_clear,
  output logic [NUM_CH-1:0]     ch_run,
  output logic                  irq,
  input  logic [AW-1:0]         S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [AW-1:0]         S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  input  logic [2:0]            S_AXI_ARPROT,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int BW = AW - 4;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [BW-1:0] aw_blk, ar_blk;
  glob_reg_e     aw_greg, ar_greg;
  ch_reg_e       aw_creg, ar_creg;
  logic          aw_ok, ar_ok;
  logic          wr_hs, rd_hs, wr_glob, clr_all;
  logic [31:0]   rd_data;
  logic [1:0]    rd_resp;
  logic [31:0]   irq_status_rd, irq_enable_rd;
  logic [NUM_CH-1:0] irq_set;
  logic [31:0]   lap_w   [NUM_CH];
  logic [31:0]   alarm_w [NUM_CH];
  logic          unused_ok;

  // Block 0 is global; blocks 1..NUM_CH are channels
  assign aw_blk  = S_AXI_AWADDR[AW-1:4];
  assign ar_blk  = S_AXI_ARADDR[AW-1:4];
  assign aw_greg = glob_reg_e'(S_AXI_AWADDR[3:2]);
  assign ar_greg = glob_reg_e'(S_AXI_ARADDR[3:2]);
  assign aw_creg = ch_reg_e'(S_AXI_AWADDR[3:2]);
  assign ar_creg = ch_reg_e'(S_AXI_ARADDR[3:2]);
  assign aw_ok   = aw_blk <= BW'(NUM_CH);
  assign ar_ok   = ar_blk <= BW'(NUM_CH);

  assign wr_hs   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs   = arready_q && S_AXI_ARVALID;
  assign wr_glob = wr_hs && (aw_blk == '0);
  assign clr_all = wr_glob && (aw_greg == G_CTRL)
                && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stopwatch_axi_channel u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_hs && (aw_blk == BW'(i + 1))),
      .wr_reg     (aw_creg),
      .wdata      (S_AXI_WDATA),
      .wstrb      (S_AXI_WSTRB),
      .clr_all    (clr_all),
      .ch_time    (ch_time[32*i +: 32]),
      .test_value (test_value[32*i +: 32]),
      .apply      (apply_test_value[i]),
      .clear      (ch_clear[i]),
      .run        (ch_run[i]),
      .lap        (lap_w[i]),
      .alarm      (alarm_w[i]),
      .irq_set    (irq_set[i])
    );
  end

`ifdef STOPWATCH_ALARM_EN
  logic [NUM_CH-1:0] irq_status_q, irq_status_d;
  logic [NUM_CH-1:0] irq_enable_q, irq_enable_d;

  // A set arriving with a W1C on the same edge wins
  always_comb begin
    irq_status_d = irq_status_q;
    irq_enable_d = irq_enable_q;
    if (wr_glob && S_AXI_WSTRB[0]) begin
      if (aw_greg == G_IRQ_STATUS)
        irq_status_d = irq_status_q & ~S_AXI_WDATA[NUM_CH-1:0];
      if (aw_greg == G_IRQ_ENABLE)
        irq_enable_d = S_AXI_WDATA[NUM_CH-1:0];
    end
    irq_status_d = irq_status_d | irq_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status_q <= '0;
      irq_enable_q <= '0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
    end
  end

  assign irq           = |(irq_status_q & irq_enable_q);
  assign irq_status_rd = 32'(irq_status_q);
  assign irq_enable_rd = 32'(irq_enable_q);
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign irq           = 1'b0;
  assign irq_status_rd = '0;
  assign irq_enable_rd = '0;
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, irq_set,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_blk == '0) begin
      unique case (ar_greg)
        G_VERSION:    rd_data = VERSION;
        G_CTRL:       rd_data = '0;
        G_IRQ_STATUS: rd_data = irq_status_rd;
        G_IRQ_ENABLE: rd_data = irq_enable_rd;
      endcase
    end else if (!ar_ok) begin
      rd_resp = RESP_DECERR;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ar_blk == BW'(i + 1)) begin
          unique case (ar_creg)
            C_TEST_VALUE: rd_data = test_value[32*i +: 32];
            C_CTRL:       rd_data = {30'b0, ch_run[i], 1'b0};
            C_LAP:        rd_data = lap_w[i];
            C_ALARM:      rd_data = alarm_w[i];
          endcase
        end
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_hs) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_ok ? RESP_OKAY : RESP_DECERR;
        end else if (S_AXI_AWVALID && S_AXI_WVALID && !awready_q) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_data;
          rresp_d   = rd_resp;
        end else if (S_AXI_ARVALID && !arready_q) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_stopwatch_ctrl_axi.sv
// Directed self-checking bench for stopwatch_ctrl_axi.
// Alarm steps are compiled when STOPWATCH_ALARM_EN is defined.
module tb_stopwatch_ctrl_axi;

  localparam int NUM_CH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ch_time;
  logic [127:0] test_value;
  logic [3:0]   apply_test_value, ch_clear, ch_run;
  logic         irq;
  logic [7:0]   AWADDR, ARADDR;
  logic         AWVALID, AWREADY, WVALID, WREADY;
  logic         BVALID, BREADY, ARVALID, ARREADY;
  logic         RVALID, RREADY;
  logic [2:0]   AWPROT, ARPROT;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  p1_apply, p2_apply, p1_clear, p2_clear;
  logic        p1_irq, p1_bvalid;
  logic [1:0]  resp;
  logic [31:0] rd;

  stopwatch_ctrl_axi #(.AW(8), .NUM_CH(NUM_CH)) dut (
    .clk              (clk),
    .reset            (reset),
    .ch_time          (ch_time),
    .test_value       (test_value),
    .apply_test_value (apply_test_value),
    .ch_clear         (ch_clear),
    .ch_run           (ch_run),
    .irq              (irq),
    .S_AXI_AWADDR     (AWADDR),
    .S_AXI_AWVALID    (AWVALID),
    .S_AXI_AWREADY    (AWREADY),
    .S_AXI_AWPROT     (AWPROT),
    .S_AXI_WDATA      (WDATA),
    .S_AXI_WSTRB      (WSTRB),
    .S_AXI_WVALID     (WVALID),
    .S_AXI_WREADY     (WREADY),
    .S_AXI_BRESP      (BRESP),
    .S_AXI_BVALID     (BVALID),
    .S_AXI_BREADY     (BREADY),
    .S_AXI_ARADDR     (ARADDR),
    .S_AXI_ARVALID    (ARVALID),
    .S_AXI_ARREADY    (ARREADY),
    .S_AXI_ARPROT     (ARPROT),
    .S_AXI_RDATA      (RDATA),
    .S_AXI_RRESP      (RRESP),
    .S_AXI_RVALID     (RVALID),
    .S_AXI_RREADY     (RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    int n;
    @(negedge clk);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_wait", n < 20, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    p1_apply  = apply_test_value;
    p1_clear  = ch_clear;
    p1_irq    = irq;
    p1_bvalid = BVALID;
    resp      = BRESP;
    @(posedge clk); #1;
    p2_apply = apply_test_value;
    p2_clear = ch_clear;
    BREADY   = 1'b0;
  endtask

  task automatic rdr(input logic [7:0] a);
    int n;
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_wait", n < 20, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    chk("rvalid", RVALID, 1);
    rd   = RDATA;
    resp = RRESP;
    @(posedge clk); #1;
    RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; ch_time = '0;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    WDATA = '0; WSTRB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hs", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
    chk("rst_resp", {BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_tv", test_value, 0);
    chk("rst_run", ch_run, 0);
    chk("rst_pulse", {apply_test_value, ch_clear}, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b0;

    rdr(8'h00);
    chk("version", rd, 32'h0002_0000);
    chk("version_resp", resp, 0);

    wr(8'h10, 32'hDEAD_BEEF, 4'hF);
    chk("tv0_bresp", resp, 0);
    chk("tv0_bvalid", p1_bvalid, 1);
    chk("tv0_val", test_value[31:0], 32'hDEAD_BEEF);
    chk("tv0_noapply", p1_apply, 0);

    wr(8'h14, 32'h1, 4'hF);
    chk("apply_p1", p1_apply, 4'b0001);
    chk("apply_p2", p2_apply, 4'b0000);
    rdr(8'h10);
    chk("tv0_read", rd, 32'hDEAD_BEEF);
    rdr(8'h14);
    chk("ctrl0_read", rd, 0);

    wr(8'h20, 32'hFFFF_FFFF, 4'b0011);
    rdr(8'h20);
    chk("strb_read", rd, 32'h0000_FFFF);
    chk("strb_tv1", test_value[63:32], 32'h0000_FFFF);

    ch_time[63:32] = 32'd1234;
    wr(8'h24, 32'h8, 4'hF);
    chk("lap_noapply", p1_apply, 0);
    ch_time[63:32] = 32'd5000;
    rdr(8'h28);
    chk("lap_read", rd, 32'd1234);

    wr(8'h34, 32'h2, 4'hF);
    chk("run2", ch_run, 4'b0100);
    rdr(8'h34);
    chk("run2_read", rd, 32'h2);

    wr(8'h34, 32'h0, 4'b1110);
    chk("nostrb_run", ch_run, 4'b0100);
    wr(8'h14, 32'h5, 4'b1110);
    chk("nostrb_pulse", {p1_apply, p1_clear}, 0);

    wr(8'h34, 32'h6, 4'hF);
    chk("clr2_p1", p1_clear, 4'b0100);
    chk("clr2_p2", p2_clear, 4'b0000);
    chk("clr2_run", ch_run, 4'b0100);

    wr(8'h04, 32'h1, 4'hF);
    chk("gclr_p1", p1_clear, 4'b1111);
    chk("gclr_p2", p2_clear, 4'b0000);
    chk("gclr_run", ch_run, 4'b0000);

    rdr(8'h50);
    chk("dec_rresp", resp, 2'd3);
    chk("dec_rdata", rd, 0);
    wr(8'h50, 32'h1234_5678, 4'hF);
    chk("dec_bresp", resp, 2'd3);
    chk("dec_tv", test_value,
        {64'h0, 32'h0000_FFFF, 32'hDEAD_BEEF});
    rdr(8'h40);
    chk("ch3_resp", resp, 0);

    wr(8'h00, 32'h0, 4'hF);
    chk("ro_bresp", resp, 0);
    rdr(8'h00);
    chk("ro_version", rd, 32'h0002_0000);
    wr(8'h28, 32'hAA, 4'hF);
    rdr(8'h28);
    chk("ro_lap", rd, 32'd1234);

`ifdef STOPWATCH_ALARM_EN
    wr(8'h3C, 32'd100, 4'hF);
    rdr(8'h3C);
    chk("alarm_read", rd, 32'd100);
    wr(8'h0C, 32'h4, 4'hF);
    rdr(8'h0C);
    chk("ien_read", rd, 32'h4);
    wr(8'h34, 32'h2, 4'hF);
    chk("irq_idle", irq, 0);
    for (int v = 95; v <= 104; v++) begin
      @(negedge clk);
      chk("irq_ramp", irq, v > 100);
      ch_time[95:64] = v;
    end
    @(negedge clk);
    chk("irq_sticky", irq, 1);
    rdr(8'h08);
    chk("ist_read", rd, 32'h4);
    wr(8'h08, 32'h4, 4'hF);
    chk("w1c_clear", p1_irq, 0);
    chk("w1c_irq", irq, 0);
    @(negedge clk);
    ch_time[95:64] = 32'd100;
    wr(8'h08, 32'h4, 4'hF);
    chk("set_wins", p1_irq, 1);
    ch_time[95:64] = 32'd104;
    wr(8'h08, 32'h4, 4'hF);
    chk("w1c_again", p1_irq, 0);
`else
    wr(8'h3C, 32'd100, 4'hF);
    chk("alarm_bresp", resp, 0);
    rdr(8'h3C);
    chk("alarm_zero", rd, 0);
    wr(8'h0C, 32'h4, 4'hF);
    rdr(8'h0C);
    chk("ien_zero", rd, 0);
    wr(8'h34, 32'h2, 4'hF);
    ch_time[95:64] = 32'd100;
    repeat (3) @(negedge clk);
    rdr(8'h08);
    chk("ist_zero", rd, 0);
    chk("irq_tied", irq, 0);
`endif

    wr(8'h14, 32'h2, 4'hF);
    @(negedge clk);
    AWADDR = 8'h10; WDATA = 32'h1234; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    ARADDR = 8'h10; ARVALID = 1'b1; RREADY = 1'b0;
    n = 0;
    while (!(AWREADY && ARREADY) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("both_wait", n < 20, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {BVALID, RVALID}, 2'b11);
    end
    chk("same_cycle_old", RDATA, 32'hDEAD_BEEF);
    chk("hold_tv", test_value[31:0], 32'h1234);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_hs", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
    chk("mid_rdata", RDATA, 0);
    chk("mid_tv", test_value, 0);
    chk("mid_run", ch_run, 0);
    chk("mid_irq", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    rdr(8'h10);
    chk("post_tv", rd, 0);
    rdr(8'h28);
    chk("post_lap", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
